// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game blocks: colour one-hot codes,
// sequence ROM address width and the checker state type.
package genius_pkg;

  localparam int unsigned SEQ_AW = 4;

  localparam logic [3:0] GREEN  = 4'b0001;
  localparam logic [3:0] RED    = 4'b0010;
  localparam logic [3:0] YELLOW = 4'b0100;
  localparam logic [3:0] BLUE   = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RELEASE,
    WAIT_PRESS
  } chk_state_t;

endpackage

// File: rtl/press_timer.sv
// Per-press timeout counter, shared by the checker and the playback block.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : synchronous clear to zero (has priority over en_i)
//   en_i        : count one step per cycle
//   expired_o   : counter has reached TIMEOUT_CYC-1
// The counter saturates at TIMEOUT_CYC-1 and never wraps.
module press_timer #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/seq_checker.sv
// Player-input checker for the Genius game. Walks the stored colour sequence
// through the ROM port and judges each debounced press against it.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle round request, ignored while busy
//   last_idx    : index of the last entry to check, captured on start
//   btn         : debounced buttons, one-hot per colour when pressed alone
//   rom_addr    : sequence ROM address
//   rom_data    : one-hot expected colour at rom_addr
//   busy        : high whenever not idle
//   round_ok    : one-cycle pulse, whole round matched
//   fail        : one-cycle pulse, round lost
//   fail_cause  : 0 = wrong colour, 1 = timeout; held until the next fail
module seq_checker
  import genius_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEQ_AW-1:0] last_idx,
  input  logic [3:0]        btn,
  output logic [SEQ_AW-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic              busy,
  output logic              round_ok,
  output logic              fail,
  output logic              fail_cause
);

  chk_state_t        state_q, state_d;
  logic [SEQ_AW-1:0] addr_q, addr_d;
  logic [SEQ_AW-1:0] last_q, last_d;
  logic              ok_q, ok_d;
  logic              fail_q, fail_d;
  logic              cause_q, cause_d;
  logic              tmr_clr, tmr_expired;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    ok_d    = 1'b0;
    fail_d  = 1'b0;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start) begin
          last_d  = last_idx;
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (btn == '0) begin
          state_d = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        // A press always takes precedence over a timeout on the same edge.
        if (btn != '0) begin
          if (btn == rom_data) begin
            if (addr_q == last_q) begin
              ok_d    = 1'b1;
              addr_d  = '0;
              state_d = IDLE;
            end else begin
              addr_d  = addr_q + SEQ_AW'(1);
              state_d = WAIT_RELEASE;
            end
          end else begin
            fail_d  = 1'b1;
            cause_d = 1'b0;
            addr_d  = '0;
            state_d = IDLE;
          end
        end else if (tmr_expired) begin
          fail_d  = 1'b1;
          cause_d = 1'b1;
          addr_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        addr_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      ok_q    <= ok_d;
      fail_q  <= fail_d;
      cause_q <= cause_d;
    end
  end

  // Clearing on either side of a WAIT_PRESS boundary keeps the timer at zero
  // everywhere outside WAIT_PRESS and starts every wait from zero.
  assign tmr_clr = (state_q != WAIT_PRESS) || (state_d != WAIT_PRESS);

  press_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (tmr_clr),
    .en_i      (1'b1),
    .expired_o (tmr_expired)
  );

  assign rom_addr   = addr_q;
  assign busy       = (state_q != IDLE);
  assign round_ok   = ok_q;
  assign fail       = fail_q;
  assign fail_cause = cause_q;

endmodule

// File: tb/tb_seq_checker.sv
// Scoreboard bench for seq_checker: the driver pushes the expected pulse
// (kind, cause, cycle) when it issues the judging stimulus; a monitor pops
// and compares whenever round_ok or fail is seen.
module tb_seq_checker;

  localparam int T      = 20;
  localparam int A_OK   = 0;
  localparam int A_BAD  = 1;
  localparam int A_TO   = 2;
  localparam int A_EDGE = 3;
  localparam int A_RST  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] last_idx = '0;
  logic [3:0] btn = '0;
  logic [3:0] rom_addr, rom_data;
  logic       busy, round_ok, fail, fail_cause;

  logic [3:0] rom [16];
  int         act [16];
  logic [3:0] bad [16];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit is_fail;
    bit cause;
    int cyc;
  } ev_t;

  ev_t expq[$];
  ev_t mon_e;
  bit  last_cause = 1'b0;

  seq_checker #(.TIMEOUT_CYC(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .last_idx   (last_idx),
    .btn        (btn),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .busy       (busy),
    .round_ok   (round_ok),
    .fail       (fail),
    .fail_cause (fail_cause)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rom_data = rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_cause = 1'b0;
    end else begin
      if (round_ok || fail) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: round_ok=%0d fail=%0d at cycle %0d, none expected",
                   round_ok, fail, cyc);
        end else begin
          mon_e = expq.pop_front();
          chk("pulse_fail", 32'(fail), 32'(mon_e.is_fail));
          chk("pulse_ok", 32'(round_ok), 32'(!mon_e.is_fail));
          chk("pulse_cycle", cyc, mon_e.cyc);
          if (mon_e.is_fail) begin
            chk("fail_cause", 32'(fail_cause), 32'(mon_e.cause));
            last_cause = mon_e.cause;
          end
        end
      end
      if (!fail) chk("cause_hold", 32'(fail_cause), 32'(last_cause));
    end
  end

  task automatic set_all_ok();
    for (int i = 0; i < 16; i++) begin
      act[i] = A_OK;
      bad[i] = '0;
    end
  endtask

  // One round: start, then per index a release phase followed by the action.
  task automatic run_round(input int last, input logic [3:0] held, input bit poke);
    bit  done;
    int  d, h, entry, judge;
    ev_t e;
    @(negedge clk);
    start = 1'b1;
    last_idx = 4'(last);
    btn = held;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("addr_at_start", 32'(rom_addr), 0);
    if (held != '0) repeat (2) @(negedge clk);
    done = 1'b0;
    for (int i = 0; i <= last && !done; i++) begin
      btn = '0;
      entry = cyc + 1;
      if (poke && i == 1) begin
        @(negedge clk);
        start = 1'b1;
        last_idx = '0;
        @(negedge clk);
        start = 1'b0;
      end
      case (act[i])
        A_TO: begin
          chk("addr_before_timeout", 32'(rom_addr), i);
          e = '{is_fail: 1'b1, cause: 1'b1, cyc: entry + T};
          expq.push_back(e);
          repeat (T + 2) @(negedge clk);
          done = 1'b1;
        end
        A_RST: begin
          repeat (3) @(negedge clk);
          chk("addr_before_reset", 32'(rom_addr), i);
          #2 rst_n = 1'b0;
          #1;
          chk("rst_busy", 32'(busy), 0);
          chk("rst_round_ok", 32'(round_ok), 0);
          chk("rst_fail", 32'(fail), 0);
          chk("rst_fail_cause", 32'(fail_cause), 0);
          chk("rst_rom_addr", 32'(rom_addr), 0);
          repeat (2) @(negedge clk);
          #2 rst_n = 1'b1;
          done = 1'b1;
        end
        default: begin
          if (act[i] == A_EDGE) begin
            repeat (T) @(negedge clk);
          end else begin
            d = $urandom_range(0, 3);
            repeat (d + 1) @(negedge clk);
          end
          chk("addr_before_press", 32'(rom_addr), i);
          judge = cyc + 1;
          if (act[i] == A_BAD) begin
            btn = bad[i];
            e = '{is_fail: 1'b1, cause: 1'b0, cyc: judge};
            expq.push_back(e);
            done = 1'b1;
          end else begin
            btn = rom[i];
            if (i == last) begin
              e = '{is_fail: 1'b0, cause: 1'b0, cyc: judge};
              expq.push_back(e);
            end
          end
          h = $urandom_range(1, 3);
          repeat (h) @(negedge clk);
        end
      endcase
    end
    btn = '0;
    repeat (3) @(negedge clk);
    chk("busy_after_round", 32'(busy), 0);
    chk("addr_after_round", 32'(rom_addr), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, last;
    bit poke;
    logic [3:0] held, v;
    rom[0] = 4'b0001;
    rom[1] = 4'b0100;
    rom[2] = 4'b0010;
    rom[3] = 4'b1000;
    for (int i = 4; i < 16; i++) rom[i] = 4'b0001 << ((i * 3) % 4);

    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_round_ok", 32'(round_ok), 0);
    chk("reset_fail", 32'(fail), 0);
    chk("reset_fail_cause", 32'(fail_cause), 0);
    chk("reset_rom_addr", 32'(rom_addr), 0);
    #2 rst_n = 1'b1;

    set_all_ok();
    run_round(3, '0, 1'b0);
    set_all_ok(); act[1] = A_BAD; bad[1] = 4'b0010;
    run_round(3, '0, 1'b0);
    set_all_ok(); act[0] = A_TO;
    run_round(3, '0, 1'b0);
    set_all_ok(); act[0] = A_EDGE;
    run_round(3, '0, 1'b0);
    set_all_ok();
    run_round(3, 4'b0001, 1'b0);
    set_all_ok(); act[0] = A_BAD; bad[0] = 4'b0101;
    run_round(3, 4'b0001, 1'b0);
    set_all_ok();
    run_round(3, '0, 1'b1);
    set_all_ok(); act[2] = A_RST;
    run_round(3, '0, 1'b0);
    set_all_ok();
    run_round(3, '0, 1'b0);
    run_round(15, '0, 1'b0);
    run_round(0, '0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      last = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 5));
      held = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      poke = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 16; i++) begin
        p = $urandom_range(0, 99);
        if (p < 82) act[i] = A_OK;
        else if (p < 88) act[i] = A_BAD;
        else if (p < 93) act[i] = A_TO;
        else if (p < 97) act[i] = A_EDGE;
        else act[i] = A_RST;
        do v = 4'($urandom_range(1, 15)); while (v == rom[i]);
        bad[i] = v;
      end
      if (poke && act[1] != A_BAD) act[1] = A_OK;
      run_round(last, held, poke);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
# seq_checker

Player-input checker for the Genius game. It reads the stored colour sequence through a ROM address/data port and compares each debounced player button press against the expected colour. It reports round success, mismatch or timeout to the game controller. It sits between the synchronised/debounced button inputs, the sequence ROM and the top-level game FSM.

## Interface
- `TIMEOUT_CYC`, default 50_000_000: clock cycles allowed per press (1 s at 50 MHz); minimum 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request to check a round; ignored while `busy`.
- `last_idx` in 4: index of the last entry to check (round length − 1); sampled only when `start` is accepted.
- `btn` in 4: synchronised, debounced buttons, active-high, one bit per colour.
- `rom_addr` out 4: sequence ROM address.
- `rom_data` in 4: one-hot expected colour, combinational from `rom_addr`.
- `busy` out 1: high whenever state ≠ IDLE.
- `round_ok` out 1: one-cycle pulse; the whole round matched.
- `fail` out 1: one-cycle pulse; the round is lost.
- `fail_cause` out 1: valid with `fail`. 0 means wrong colour, 1 means timeout. Holds its value until the next `fail`.

## Operation
- States:
  - IDLE
  - WAIT_RELEASE: all buttons must be up.
  - WAIT_PRESS: waiting for the next press.
- IDLE:
  - `rom_addr`=0, timer=0.
  - `start`=1 captures `last_idx` into `last_q` and moves to WAIT_RELEASE.
- WAIT_RELEASE: `btn`==0000 moves to WAIT_PRESS with timer=0. The timer does not run in this state.
- WAIT_PRESS: the timer increments every cycle.
  - `btn`≠0000: the press is judged on that edge.
  - Match means `btn`==`rom_data` exactly. Two or more buttons held, or any other value, is a mismatch.
  - Match with `rom_addr`==`last_q`: pulse `round_ok`, go to IDLE.
  - Match with `rom_addr`<`last_q`: `rom_addr`+1, go to WAIT_RELEASE.
  - Mismatch: pulse `fail` with `fail_cause`=0, go to IDLE.
  - Timer reaches `TIMEOUT_CYC`−1 with `btn`==0000: pulse `fail` with `fail_cause`=1, go to IDLE.
- Simultaneous events:
  - A press and timer expiry on the same edge: the press wins and is judged normally.
  - `start` on the same edge as `round_ok`/`fail`: ignored, because the block is still busy on that edge.
  - `start` while a button is held: accepted; the block stays in WAIT_RELEASE until the button is released.
- A round therefore never wraps. With `last_idx`=15, a match at address 15 ends the round. `rom_addr` never increments past `last_q`.
- Reset at any time, including mid-round:
  - state=IDLE, `rom_addr`=0, timer=0, `last_q`=0.
  - `busy`=0, `round_ok`=0, `fail`=0, `fail_cause`=0.
  - No pulse is generated on reset exit.

## Timing
- All outputs are registered. `busy` is decoded from the state register.
- `start` sampled at edge N gives `busy`=1 after edge N.
- A judging press sampled at edge N gives `round_ok` or `fail` high from edge N to edge N+1, exactly one cycle. `busy` falls at edge N.
- `rom_addr` updates at the judging edge. The new `rom_data` is required to be stable before the next WAIT_PRESS sample, which is at least 1 cycle later because of WAIT_RELEASE.
- Timeout occurs `TIMEOUT_CYC` cycles after entry to WAIT_PRESS: the edges numbered 0..`TIMEOUT_CYC`−1, counting the entry edge as 0.
- Timer width is clog2(`TIMEOUT_CYC`). The timer saturates and never wraps.

## Structure
- Shared package `genius_pkg`:
  - Colour one-hot constants: GREEN=0001, RED=0010, YELLOW=0100, BLUE=1000.
  - Address width constant SEQ_AW=4.
  - State enum `chk_state_t` {IDLE, WAIT_RELEASE, WAIT_PRESS}.
- One sub-module, `press_timer`: clear/enable counter with `expired` output, parameterised by `TIMEOUT_CYC`. It is reused later by the playback block.

## Test plan
Bench ROM model returns 0001, 0100, 0010, 1000 at addresses 0..3. `TIMEOUT_CYC`=20.
- Full correct round: `start` with `last_idx`=3, then press 0001, 0100, 0010, 1000, each followed by release → `round_ok` is one cycle high after the 4th press, `fail` never asserts, `rom_addr` returns to 0.
- Wrong colour: `last_idx`=3, press 0001, then 0010 at address 1 → `fail`=1 for one cycle with `fail_cause`=0, `busy`=0 the next cycle.
- Timeout: `start`, no press for 20 cycles in WAIT_PRESS → `fail` with `fail_cause`=1. A press arriving exactly on the expiry edge instead gives a match and advances `rom_addr` to 1.
- Held button at start: `btn`=0001 held across `start` → no judgement until release, then the next 0001 press matches address 0. Pressing 0101 instead gives a mismatch.
- `start` while busy with `last_idx`=0 → ignored; the original `last_q`=3 governs the round.
- Reset: assert `rst_n`=0 at address 2 in WAIT_PRESS → all outputs 0 immediately, no pulse after release, a new `start` begins at address 0.
